// File: rtl/nn_pkg.sv
// Shared definitions for the NN datapath write-back path: FSM states and sizing helpers.
package nn_pkg;

    // Write-back controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } wb_state_e;

    localparam int unsigned DEF_ACC_W     = 16;
    localparam int unsigned DEF_N_MACS    = 4;
    localparam int unsigned DEF_N         = 4;
    localparam int unsigned DEF_MEM_DEPTH = 256;
    localparam int unsigned DEF_BRAM_W    = 64;

    // Elements packed into one BRAM word
    function automatic int unsigned elems_per_word(input int unsigned bram_w,
                                                   input int unsigned acc_w);
        return bram_w / acc_w;
    endfunction

    // Bits needed to index n items (at least 1)
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold a count from 0 to n inclusive
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nn_lane_compact.sv
// Popcount and prefix rank of a per-lane valid mask: rank[k] = set bits below lane k.
module nn_lane_compact
    import nn_pkg::*;
#(
    parameter int unsigned N_MACS = DEF_N_MACS,
    parameter int unsigned RANK_W = cnt_w(N_MACS)
) (
    input  logic [N_MACS-1:0]             valid,
    output logic [N_MACS-1:0][RANK_W-1:0] rank,
    output logic [RANK_W-1:0]             count
);

    logic [RANK_W-1:0] run;

    // Running count of valid lanes gives each lane its slot offset within the beat
    always_comb begin
        run  = '0;
        rank = '0;
        for (int k = 0; k < N_MACS; k++) begin
            rank[k] = run;
            run     = run + RANK_W'(valid[k]);
        end
        count = run;
    end

endmodule

// File: rtl/nn_result_writer.sv
// Packs per-lane accumulator results LSB-first into BRAM words and writes them to the result BRAM.
// Optional build macro NN_WB_RELU_EN: apply ReLU to each accepted element before staging.
module nn_result_writer
    import nn_pkg::*;
#(
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned N_MACS    = DEF_N_MACS,
    parameter int unsigned N         = DEF_N,
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int unsigned BRAM_W    = DEF_BRAM_W,
    parameter int unsigned ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [N_MACS*ACC_W-1:0]  acc_in,
    input  logic [N_MACS-1:0]        valid_in,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic                     bram_en,
    output logic                     bram_we,
    output logic [BRAM_W-1:0]        bram_din,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int unsigned EPW    = elems_per_word(BRAM_W, ACC_W);
    localparam int unsigned SLOTS  = 2 * EPW;
    localparam int unsigned SLOT_W = idx_w(SLOTS);
    localparam int unsigned PTR_W  = SLOT_W + 1;
    localparam int unsigned RANK_W = cnt_w(N_MACS);
    localparam int unsigned CNT_W  = cnt_w(N + N_MACS);
    localparam int unsigned ASUM_W = ADDR_W + 1;

    if ((BRAM_W % ACC_W) != 0) begin : g_bad_word
        $error("nn_result_writer: BRAM_W must be a multiple of ACC_W");
    end
    if (EPW < N_MACS) begin : g_bad_lanes
        $error("nn_result_writer: a BRAM word must hold at least N_MACS elements");
    end

    wb_state_e                       state;
    logic [ADDR_W-1:0]               base_q;
    logic [CNT_W-1:0]                elem_cnt;
    logic [ADDR_W-1:0]               word_cnt;
    logic [SLOT_W-1:0]               slot_ptr;
    logic [SLOTS-1:0][ACC_W-1:0]     stage;
    logic                            pend;
    logic                            pend_hi;

    logic [N_MACS-1:0][RANK_W-1:0]   beat_rank;
    logic [RANK_W-1:0]               beat_cnt;

    logic [CNT_W-1:0]                remaining;
    logic [CNT_W-1:0]                beat_cnt_w;
    logic [CNT_W-1:0]                take;
    logic                            dropped;
    logic [ACC_W-1:0]                lane_val;
    logic [PTR_W-1:0]                slot_sum;
    logic [SLOTS-1:0][ACC_W-1:0]     stage_nx;
    logic [SLOTS-1:0][ACC_W-1:0]     stage_upd;
    logic [PTR_W-1:0]                ptr_sum;
    logic [SLOT_W-1:0]               new_ptr;
    logic                            done_lo;
    logic                            done_hi;
    logic                            is_last;
    logic                            partial;
    logic                            part_hi;
    logic                            pend_nx;
    logic [BRAM_W-1:0]               word_lo;
    logic [BRAM_W-1:0]               word_hi;
    logic                            wr_req;
    logic [BRAM_W-1:0]               wr_data;
    logic [ASUM_W-1:0]               addr_sum;
    logic [ADDR_W-1:0]               wr_addr;
    logic [ASUM_W-1:0]               wcnt_sum;
    logic [ADDR_W-1:0]               word_cnt_inc;

    nn_lane_compact #(
        .N_MACS (N_MACS),
        .RANK_W (RANK_W)
    ) u_compact (
        .valid (valid_in),
        .rank  (beat_rank),
        .count (beat_cnt)
    );

    // Beat acceptance, staging update and selection of the word to write this cycle
    always_comb begin
        remaining  = CNT_W'(N) - elem_cnt;
        beat_cnt_w = CNT_W'(beat_cnt);
        take       = '0;
        dropped    = 1'b0;
        if (state == COLLECT) begin
            take    = (beat_cnt_w > remaining) ? remaining : beat_cnt_w;
            dropped = (beat_cnt_w > remaining);
        end

        stage_nx = stage;
        lane_val = '0;
        slot_sum = '0;
        for (int k = 0; k < N_MACS; k++) begin
            if (valid_in[k] && (CNT_W'(beat_rank[k]) < take)) begin
                lane_val = acc_in[k*ACC_W +: ACC_W];
`ifdef NN_WB_RELU_EN
                if (lane_val[ACC_W-1]) begin
                    lane_val = '0;
                end
`endif
                slot_sum = PTR_W'(slot_ptr) + PTR_W'(beat_rank[k]);
                if (slot_sum >= PTR_W'(SLOTS)) begin
                    slot_sum = slot_sum - PTR_W'(SLOTS);
                end
                stage_nx[SLOT_W'(slot_sum)] = lane_val;
            end
        end

        // A staging half completes when the fill pointer crosses its upper edge
        ptr_sum = PTR_W'(slot_ptr) + PTR_W'(take);
        done_lo = (slot_ptr < SLOT_W'(EPW)) && (ptr_sum >= PTR_W'(EPW));
        done_hi = (slot_ptr >= SLOT_W'(EPW)) && (ptr_sum >= PTR_W'(SLOTS));
        new_ptr = (ptr_sum >= PTR_W'(SLOTS)) ? SLOT_W'(ptr_sum - PTR_W'(SLOTS))
                                             : SLOT_W'(ptr_sum);
        is_last = (take != '0) && ((elem_cnt + take) == CNT_W'(N));
        partial = is_last && (new_ptr != '0) && (new_ptr != SLOT_W'(EPW));
        part_hi = (new_ptr >= SLOT_W'(EPW));

        word_lo = stage_nx[EPW-1:0];
        word_hi = stage_nx[SLOTS-1:EPW];

        wr_req    = 1'b0;
        wr_data   = '0;
        pend_nx   = 1'b0;
        stage_upd = stage_nx;
        if (done_lo) begin
            stage_upd[EPW-1:0] = '0;
        end
        if (done_hi) begin
            stage_upd[SLOTS-1:EPW] = '0;
        end
        if (done_lo || done_hi) begin
            // Full word wins the port; a trailing partial word waits one FLUSH cycle
            wr_req  = 1'b1;
            wr_data = done_hi ? word_hi : word_lo;
            pend_nx = partial;
        end else if (partial) begin
            wr_req  = 1'b1;
            wr_data = part_hi ? word_hi : word_lo;
        end
        if (is_last && !pend_nx) begin
            stage_upd = '0;
        end
        if ((state == FLUSH) && pend) begin
            wr_req  = 1'b1;
            wr_data = pend_hi ? BRAM_W'(stage[SLOTS-1:EPW]) : BRAM_W'(stage[EPW-1:0]);
        end

        addr_sum = ASUM_W'(base_q) + ASUM_W'(word_cnt);
        if (addr_sum >= ASUM_W'(MEM_DEPTH)) begin
            addr_sum = addr_sum - ASUM_W'(MEM_DEPTH);
        end
        wr_addr = ADDR_W'(addr_sum);

        wcnt_sum = ASUM_W'(word_cnt) + ASUM_W'(1);
        if (wcnt_sum >= ASUM_W'(MEM_DEPTH)) begin
            wcnt_sum = '0;
        end
        word_cnt_inc = ADDR_W'(wcnt_sum);
    end

    // Controller FSM, counters, staging and registered BRAM/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            elem_cnt  <= '0;
            word_cnt  <= '0;
            slot_ptr  <= '0;
            stage     <= '0;
            pend      <= 1'b0;
            pend_hi   <= 1'b0;
            bram_addr <= '0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_din  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            bram_en <= 1'b0;
            bram_we <= 1'b0;
            done    <= 1'b0;
            if (wr_req) begin
                bram_en   <= 1'b1;
                bram_we   <= 1'b1;
                bram_addr <= wr_addr;
                bram_din  <= wr_data;
                word_cnt  <= word_cnt_inc;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        base_q   <= base_addr;
                        elem_cnt <= '0;
                        word_cnt <= '0;
                        slot_ptr <= '0;
                        stage    <= '0;
                        pend     <= 1'b0;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                    end
                    if (valid_in != '0) begin
                        overflow <= 1'b1;
                    end
                end
                COLLECT: begin
                    elem_cnt <= elem_cnt + take;
                    slot_ptr <= new_ptr;
                    stage    <= stage_upd;
                    if (dropped) begin
                        overflow <= 1'b1;
                    end
                    if (is_last) begin
                        state   <= FLUSH;
                        pend    <= pend_nx;
                        pend_hi <= part_hi;
                    end
                end
                FLUSH: begin
                    if (valid_in != '0) begin
                        overflow <= 1'b1;
                    end
                    if (pend) begin
                        pend  <= 1'b0;
                        stage <= '0;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (valid_in != '0) begin
                        overflow <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_result_writer.sv
// Bench for nn_result_writer: three instances (N = 4, 8, 6), directed steps then randomized vectors.
module tb_nn_result_writer;

    logic        clk;
    logic        rst_n;
    logic        start [3];
    logic [3:0]  valid [3];
    logic [7:0]  base;
    logic [63:0] acc;

    logic [7:0]  addr [3];
    logic        en   [3];
    logic        we   [3];
    logic [63:0] din  [3];
    logic        busy [3];
    logic        done [3];
    logic        ovf  [3];

    int checks;
    int errors;
    int done_cnt [3];
    logic [71:0] wq0[$];
    logic [71:0] wq1[$];
    logic [71:0] wq2[$];

    nn_result_writer #(.N(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .base_addr(base), .acc_in(acc),
        .valid_in(valid[0]), .bram_addr(addr[0]), .bram_en(en[0]), .bram_we(we[0]),
        .bram_din(din[0]), .busy(busy[0]), .done(done[0]), .overflow(ovf[0]));

    nn_result_writer #(.N(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .base_addr(base), .acc_in(acc),
        .valid_in(valid[1]), .bram_addr(addr[1]), .bram_en(en[1]), .bram_we(we[1]),
        .bram_din(din[1]), .busy(busy[1]), .done(done[1]), .overflow(ovf[1]));

    nn_result_writer #(.N(6)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .base_addr(base), .acc_in(acc),
        .valid_in(valid[2]), .bram_addr(addr[2]), .bram_en(en[2]), .bram_we(we[2]),
        .bram_din(din[2]), .busy(busy[2]), .done(done[2]), .overflow(ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every BRAM write ({addr, din}, we must accompany en) and every done pulse
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                case (i)
                    0:       wq0.push_back({addr[i], din[i]});
                    1:       wq1.push_back({addr[i], din[i]});
                    default: wq2.push_back({addr[i], din[i]});
                endcase
            end
            if (done[i]) done_cnt[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int i, input logic [7:0] b);
        base     = b;
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic beat(input int i, input logic [3:0] v, input logic [63:0] a);
        acc      = a;
        valid[i] = v;
        tick();
        valid[i] = 4'b0000;
    endtask

    function automatic logic [63:0] p4(input logic [15:0] l3, input logic [15:0] l2,
                                       input logic [15:0] l1, input logic [15:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [15:0] stored(input logic [15:0] x);
`ifdef NN_WB_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    function automatic int n_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 8 : 6);
    endfunction

    // write-port view: {en, we, addr, din}
    function automatic logic [79:0] wr_view(input int i);
        return 80'({en[i], we[i], addr[i], din[i]});
    endfunction

    function automatic logic [79:0] wr_exp(input logic [7:0] a, input logic [63:0] d);
        return 80'({1'b1, 1'b1, a, d});
    endfunction

    initial begin
        logic [7:0]  b;
        logic [3:0]  vv;
        logic [63:0] a;
        logic [63:0] word;
        logic [15:0] elems[$];
        logic [71:0] q[$];
        logic        idle;
        logic        stray;
        int          n;
        int          nw;
        int          qb [3];
        int          db [3];

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        base   = '0;
        acc    = '0;
        for (int i = 0; i < 3; i++) begin
            start[i]    = 1'b0;
            valid[i]    = 4'b0000;
            done_cnt[i] = 0;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk("reset_outputs", 80'({addr[i], en[i], we[i], din[i], busy[i], done[i], ovf[i]}), 80'(0));
        end
        rst_n = 1'b1;
        tick();

        // single full beat, one word
        do_start(0, 8'd2);
        chk("t1_busy_after_start", 80'(busy[0]), 80'(1));
        beat(0, 4'b1111, p4(4, 3, 2, 1));
        chk("t1_write", wr_view(0), wr_exp(8'd2, p4(4, 3, 2, 1)));
        tick();
        chk("t1_done_cycle", 80'({done[0], busy[0], en[0]}), 80'(3'b100));
        tick();
        chk("t1_done_pulse_end", 80'(done[0]), 80'(0));

        // two half beats make one word
        do_start(0, 8'd5);
        beat(0, 4'b0011, p4(0, 0, 6, 5));
        chk("t2_no_early_write", 80'(en[0]), 80'(0));
        beat(0, 4'b0011, p4(0, 0, 8, 7));
        chk("t2_write", wr_view(0), wr_exp(8'd5, p4(8, 7, 6, 5)));
        tick();
        chk("t2_done", 80'({done[0], busy[0]}), 80'(2'b10));
        tick();

        // N=8: straddling beat, last word written during FLUSH
        do_start(1, 8'd10);
        beat(1, 4'b0111, p4(0, 3, 2, 1));
        chk("t3_no_write_beat1", 80'(en[1]), 80'(0));
        beat(1, 4'b1111, p4(7, 6, 5, 4));
        chk("t3_write0", wr_view(1), wr_exp(8'd10, p4(4, 3, 2, 1)));
        beat(1, 4'b0001, p4(0, 0, 0, 8));
        chk("t3_write1", wr_view(1), wr_exp(8'd11, p4(8, 7, 6, 5)));
        chk("t3_busy_in_flush", 80'(busy[1]), 80'(1));
        tick();
        chk("t3_done", 80'({done[1], busy[1], en[1]}), 80'(3'b100));
        tick();

        // N=6 at base 255: address wrap and zero-padded partial word
        do_start(2, 8'd255);
        beat(2, 4'b1111, p4(4, 3, 2, 1));
        chk("t4_write0", wr_view(2), wr_exp(8'd255, p4(4, 3, 2, 1)));
        beat(2, 4'b0011, p4(0, 0, 6, 5));
        chk("t4_write1_wrap_pad", wr_view(2), wr_exp(8'd0, p4(0, 0, 6, 5)));
        tick();
        chk("t4_done", 80'({done[2], busy[2]}), 80'(2'b10));
        tick();

        // negative values, then valid while idle
        do_start(0, 8'd7);
        beat(0, 4'b1111, p4(16'h0000, 16'hFFFF, 16'h0002, 16'hFFFD));
`ifdef NN_WB_RELU_EN
        chk("t5_signed_word", wr_view(0), wr_exp(8'd7, 64'h0000_0000_0002_0000));
`else
        chk("t5_signed_word", wr_view(0), wr_exp(8'd7, 64'h0000_FFFF_0002_FFFD));
`endif
        tick();
        tick();
        valid[0] = 4'b1111;
        tick();
        valid[0] = 4'b0000;
        chk("t5_idle_valid", 80'({ovf[0], en[0]}), 80'(2'b10));
        do_start(0, 8'd0);
        chk("t5_start_clears_ovf", 80'(ovf[0]), 80'(0));
        beat(0, 4'b1111, p4(9, 9, 9, 9));
        tick();
        tick();

        // asynchronous reset mid-vector
        do_start(0, 8'd20);
        beat(0, 4'b0011, p4(0, 0, 2, 1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", 80'({addr[0], en[0], we[0], din[0], busy[0], done[0], ovf[0]}), 80'(0));
        tick();
        tick();
        rst_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (en[0]) stray = 1'b1;
        end
        chk("t6_no_write_after_reset", 80'(stray), 80'(0));
        do_start(0, 8'd30);
        beat(0, 4'b1111, p4(4, 3, 2, 1));
        chk("t6_clean_write", wr_view(0), wr_exp(8'd30, p4(4, 3, 2, 1)));
        tick();
        chk("t6_clean_done", 80'(done[0]), 80'(1));
        tick();

        // randomized vectors against an element-list model of all three instances
        for (int v = 0; v < 25; v++) begin
            b = 8'($urandom);
            elems.delete();
            qb[0] = wq0.size();
            qb[1] = wq1.size();
            qb[2] = wq2.size();
            for (int i = 0; i < 3; i++) db[i] = done_cnt[i];
            base = b;
            for (int i = 0; i < 3; i++) start[i] = 1'b1;
            tick();
            for (int i = 0; i < 3; i++) start[i] = 1'b0;
            while (elems.size() < 8) begin
                vv = 4'($urandom_range(0, 15));
                a  = {$urandom, $urandom};
                for (int k = 0; k < 4; k++) begin
                    if (vv[k]) elems.push_back(a[k*16 +: 16]);
                end
                acc = a;
                for (int i = 0; i < 3; i++) valid[i] = vv;
                tick();
                for (int i = 0; i < 3; i++) valid[i] = 4'b0000;
                if ($urandom_range(0, 3) == 0) tick();
            end
            idle = 1'b0;
            for (int c = 0; c < 12 && !idle; c++) begin
                tick();
                idle = !busy[0] && !done[0] && !busy[1] && !done[1] && !busy[2] && !done[2];
            end
            chk("rnd_idle_timeout", 80'(idle), 80'(1));
            tick();
            for (int i = 0; i < 3; i++) begin
                n  = n_of(i);
                nw = (n + 3) / 4;
                case (i)
                    0:       q = wq0;
                    1:       q = wq1;
                    default: q = wq2;
                endcase
                chk("rnd_write_count", 80'(q.size() - qb[i]), 80'(nw));
                for (int w = 0; w < nw; w++) begin
                    word = '0;
                    for (int j = 0; j < 4; j++) begin
                        if (w * 4 + j < n) word[j*16 +: 16] = stored(elems[w * 4 + j]);
                    end
                    if (qb[i] + w < q.size()) begin
                        chk("rnd_write_word", 80'(q[qb[i] + w]), 80'({8'(int'(b) + w), word}));
                    end
                end
                chk("rnd_overflow", 80'(ovf[i]), 80'(elems.size() > n));
                chk("rnd_done_pulses", 80'(done_cnt[i] - db[i]), 80'(1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
